// File: rtl/des_rev_key_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : des_rev_key_sched_if
// Purpose  : Load/stream handshake bundle of the DES reverse key schedule.
// Revision : 1.0
// ============================================================================
interface des_rev_key_sched_if;
   logic        start;
   logic [1:56] key_in;
   logic        busy;
   logic        sk_valid;
   logic        sk_ready;
   logic [1:48] subkey;
   logic [4:0]  sk_num;
   logic        done;

   modport master (
      output start, key_in, sk_ready,
      input  busy, sk_valid, subkey, sk_num, done
   );

   modport slave (
      input  start, key_in, sk_ready,
      output busy, sk_valid, subkey, sk_num, done
   );
endinterface
`default_nettype wire

// File: rtl/des_rev_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : des_rev_key_sched
// Purpose  : Streams DES subkeys K16..K1 by right-rotating C/D from the PC-1 key.
// Revision : 1.0
// ============================================================================
module des_rev_key_sched (
   input  logic                  clk,
   input  logic                  rst,
   des_rev_key_sched_if.slave    bus
);

   localparam int KEY_W = 56;
   localparam int SK_W  = 48;

   // Bit n set where the DES schedule shifts by 2 for round n; indexed by sk_num
   // before the decrement, so the rotate undoes the shift that produced K_n.
   localparam logic [31:0] SHIFT2_MASK = 32'h0000_FDF8;

   localparam int PC2 [1:SK_W] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [1:28] c_q, c_d;
   logic [1:28] d_q, d_d;
   logic [4:0]  sk_num_q, sk_num_d;
   logic        done_q, done_d;

   logic [1:KEY_W] cd_w;
   logic [1:SK_W]  subkey_w;
   logic           rot2_w;

   assign cd_w   = {c_q, d_q};
   assign rot2_w = SHIFT2_MASK[sk_num_q];

   generate
      for (genvar i = 1; i <= SK_W; i++) begin : g_pc2
         assign subkey_w[i] = cd_w[PC2[i]];
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      c_d      = c_q;
      d_d      = d_q;
      sk_num_d = sk_num_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               c_d      = bus.key_in[1:28];
               d_d      = bus.key_in[29:56];
               sk_num_d = 5'd16;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (bus.sk_ready) begin
               if (sk_num_q == 5'd1) begin
                  sk_num_d = 5'd0;
                  done_d   = 1'b1;
                  state_d  = IDLE;
               end else begin
                  if (rot2_w) begin
                     c_d = {c_q[27:28], c_q[1:26]};
                     d_d = {d_q[27:28], d_q[1:26]};
                  end else begin
                     c_d = {c_q[28], c_q[1:27]};
                     d_d = {d_q[28], d_q[1:27]};
                  end
                  sk_num_d = sk_num_q - 5'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         c_q      <= '0;
         d_q      <= '0;
         sk_num_q <= 5'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         c_q      <= c_d;
         d_q      <= d_d;
         sk_num_q <= sk_num_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy     = (state_q == RUN);
   assign bus.sk_valid = (state_q == RUN);
   assign bus.subkey   = subkey_w;
   assign bus.sk_num   = sk_num_q;
   assign bus.done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_des_rev_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_rev_key_sched
// Purpose  : Directed bench for des_rev_key_sched against a forward key-schedule model.
// Revision : 1.0
// ============================================================================
module tb_des_rev_key_sched;

   localparam logic [1:56] FIPS_KEY = 56'hF0CCAAF556678F;
   localparam logic [1:56] ALT_KEY  = 56'h123456789ABCDE;

   localparam logic [5:0] PC2_TAB [0:47] = '{
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
      6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
      6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
   };

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   logic [1:48] exp_k [0:31];
   logic [1:28] exp_c1;
   logic [1:28] exp_d1;

   des_rev_key_sched_if bus_if ();

   des_rev_key_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [1:48] pc2_ref(input logic [1:56] cd);
      logic [1:48] r;
      r = '0;
      for (logic [5:0] j = 6'd0; j < 6'd48; j++) begin
         r = {r[2:48], cd[PC2_TAB[j]]};
      end
      return r;
   endfunction

   // Forward (encryption-direction) schedule: left rotates, K1 first.
   task automatic gen_keys(input logic [1:56] key);
      logic [1:28] c, d;
      c = key[1:28];
      d = key[29:56];
      for (logic [4:0] i = 5'd1; i <= 5'd16; i++) begin
         c = {c[2:28], c[1]};
         d = {d[2:28], d[1]};
         if (!(i == 5'd1 || i == 5'd2 || i == 5'd9 || i == 5'd16)) begin
            c = {c[2:28], c[1]};
            d = {d[2:28], d[1]};
         end
         if (i == 5'd1) begin
            exp_c1 = c;
            exp_d1 = d;
         end
         exp_k[i] = pc2_ref({c, d});
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check_eq({tag, "_busy"},   64'(bus_if.busy),     64'd0);
      check_eq({tag, "_valid"},  64'(bus_if.sk_valid), 64'd0);
      check_eq({tag, "_sknum"},  64'(bus_if.sk_num),   64'd0);
      check_eq({tag, "_subkey"}, 64'(bus_if.subkey),   64'd0);
      check_eq({tag, "_done"},   64'(bus_if.done),     64'd0);
   endtask

   // Start a sequence on the next edge and consume K16..K1; returns at the done cycle.
   task automatic collect(input logic [1:56] key, input bit bp, input int stray_n,
                          input logic [1:56] stray_key, input bit fips);
      int n;
      int budget;
      bit rdy;
      gen_keys(key);
      bus_if.start    = 1'b1;
      bus_if.key_in   = key;
      bus_if.sk_ready = 1'b0;
      @(negedge clk);
      bus_if.start = 1'b0;
      check_eq("busy_after_start", 64'(bus_if.busy), 64'd1);
      n = 16;
      budget = 0;
      while (n > 0 && budget < 400) begin
         check_eq("sk_valid", 64'(bus_if.sk_valid), 64'd1);
         check_eq("sk_num",   64'(bus_if.sk_num),   64'(n));
         check_eq("subkey",   64'(bus_if.subkey),   64'(exp_k[5'(n)]));
         check_eq("done_low", 64'(bus_if.done),     64'd0);
         if (fips) begin
            case (n)
               16: check_eq("fips_k16", 64'(bus_if.subkey), 64'h0000CB3D8B0E17F5);
               15: check_eq("fips_k15", 64'(bus_if.subkey), 64'h0000BF918D3D3F0A);
               2:  check_eq("fips_k2",  64'(bus_if.subkey), 64'h000079AED9DBC9E5);
               1:  check_eq("fips_k1",  64'(bus_if.subkey), 64'h00001B02EFFC7072);
               default: ;
            endcase
         end
         rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (n == stray_n) begin
            bus_if.start  = 1'b1;
            bus_if.key_in = stray_key;
         end
         bus_if.sk_ready = rdy;
         @(negedge clk);
         bus_if.start = 1'b0;
         if (rdy) n--;
         budget++;
      end
      check_eq("seq_timeout", 64'(n), 64'd0);
      check_eq("done_pulse",  64'(bus_if.done),     64'd1);
      check_eq("end_busy",    64'(bus_if.busy),     64'd0);
      check_eq("end_valid",   64'(bus_if.sk_valid), 64'd0);
      check_eq("end_sknum",   64'(bus_if.sk_num),   64'd0);
      check_eq("end_c1",      64'(dut.c_q),         64'(exp_c1));
      check_eq("end_d1",      64'(dut.d_q),         64'(exp_d1));
      bus_if.sk_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] r;
      int budget;
      n_checks        = 0;
      n_pass          = 0;
      rst             = 1'b1;
      bus_if.start    = 1'b0;
      bus_if.key_in   = '0;
      bus_if.sk_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      collect(FIPS_KEY, 1'b0, 0, '0, 1'b1);
      @(negedge clk);
      check_eq("done_one_cycle", 64'(bus_if.done), 64'd0);

      collect(FIPS_KEY, 1'b1, 0, '0, 1'b1);
      @(negedge clk);

      collect(FIPS_KEY, 1'b0, 9, ALT_KEY, 1'b1);
      @(negedge clk);

      // Asynchronous reset mid-sequence at sk_num 7.
      bus_if.start  = 1'b1;
      bus_if.key_in = FIPS_KEY;
      @(negedge clk);
      bus_if.start    = 1'b0;
      bus_if.sk_ready = 1'b1;
      budget = 0;
      while (bus_if.sk_num != 5'd7 && budget < 40) begin
         @(negedge clk);
         budget++;
      end
      check_eq("reach_sknum7", 64'(bus_if.sk_num), 64'd7);
      #2 rst = 1'b1;
      #1 check_idle_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      bus_if.sk_ready = 1'b0;
      @(negedge clk);
      check_idle_zero("post_rst");

      collect(FIPS_KEY, 1'b0, 0, '0, 1'b1);
      collect('0, 1'b0, 0, '0, 1'b0);
      collect({56{1'b1}}, 1'b0, 0, '0, 1'b0);
      @(negedge clk);

      for (int k = 0; k < 100; k++) begin
         r = {$urandom, $urandom};
         collect(r[55:0], 1'(k % 2), 0, '0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
